// File: rtl/transmit_beamform.sv
// rtl/transmit_beamform.sv - steered multi-element transmit burst generator
`timescale 1ns/1ps
module transmit_beamform #(
  parameter int NUM_TRANSMITTERS = 4,
  parameter int PERIOD_DURATION  = 16777216,
  parameter int BURST_DURATION   = 524288,
  parameter int ELEMENT_SPACING  = 9,
  parameter int SPEED_OF_SOUND   = 343000,
  parameter int TARGET_FREQ      = 40000,
  parameter int CLK_FREQ         = 100000000,
  parameter int SIN_WIDTH        = 16,
  parameter int DELAY_WIDTH      = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        enable_in,
  input  logic [SIN_WIDTH-1:0]        sin_theta_in,
  input  logic                        sign_bit_in,
  output logic [NUM_TRANSMITTERS-1:0] tx_out,
  output logic                        burst_active_out,
  output logic                        period_start_out
);

  // Inter-element delay in clocks for a full 90-degree steer, and the tone half-period.
  localparam logic [63:0] CYCLE_DELAY = (64'(ELEMENT_SPACING) * 64'(CLK_FREQ)) / 64'(SPEED_OF_SOUND);
  localparam logic [63:0] HALF        = 64'(CLK_FREQ) / (64'd2 * 64'(TARGET_FREQ));
  localparam logic [63:0] MAX_DELAY   = CYCLE_DELAY * 64'(NUM_TRANSMITTERS - 1);
  localparam logic [63:0] BURST64     = 64'(BURST_DURATION);
  localparam int          CNT_W       = (PERIOD_DURATION > 1) ? $clog2(PERIOD_DURATION) : 1;
  localparam int          PH_W        = $clog2(2 * HALF);
  localparam logic [SIN_WIDTH-1:0] SIN_ONE = {1'b1, {(SIN_WIDTH-1){1'b0}}};

  // The last element's burst must finish inside the period, and its delay must fit the register.
  if (64'(PERIOD_DURATION) <= MAX_DELAY + BURST64 + 64'd2) begin : g_bad_period
    $error("transmit_beamform: PERIOD_DURATION too short for the steered burst");
  end
  if (MAX_DELAY >= (64'd1 << DELAY_WIDTH)) begin : g_bad_delay_width
    $error("transmit_beamform: maximum delay does not fit in DELAY_WIDTH");
  end
  if (HALF == 64'd0) begin : g_bad_freq
    $error("transmit_beamform: TARGET_FREQ too high for CLK_FREQ");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic [SIN_WIDTH-1:0]          r_sin;
  logic                          r_sign;
  logic                          r_pstart;
  logic [SIN_WIDTH-1:0]          w_sin_clamped;
  logic                          w_last;
  logic                          w_at_zero;
  logic [63:0]                   w_cnt64;
  logic [NUM_TRANSMITTERS-1:0]   w_tx;
  logic [NUM_TRANSMITTERS-1:0]   w_win;

  assign w_sin_clamped = (sin_theta_in > SIN_ONE) ? SIN_ONE : sin_theta_in;
  assign w_last        = (r_cnt == CNT_W'(PERIOD_DURATION - 1));
  assign w_at_zero     = (r_state == S_RUN) && (r_cnt == '0);
  assign w_cnt64       = 64'(r_cnt);

  // Period sequencer: start on enable, run full periods, latch the angle on entry to t=0.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sin    <= '0;
      r_sign   <= 1'b0;
      r_pstart <= 1'b0;
    end else begin
      r_pstart <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable_in) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_sin    <= w_sin_clamped;
            r_sign   <= sign_bit_in;
            r_pstart <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_cnt <= '0;
            if (enable_in) begin
              r_sin    <= w_sin_clamped;
              r_sign   <= sign_bit_in;
              r_pstart <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_TRANSMITTERS; g++) begin : g_elem
    logic [63:0]            w_k;
    logic [63:0]            w_d64;
    logic                   w_start;
    logic                   w_win_next;
    logic [PH_W-1:0]        w_phase_next;
    logic [DELAY_WIDTH-1:0] r_delay;
    logic [PH_W-1:0]        r_phase;
    logic                   r_tx;
    logic                   r_win;

    // Outputs are registered, so the window test looks one cycle ahead (cnt+1).
    assign w_k          = r_sign ? 64'(NUM_TRANSMITTERS - 1 - g) : 64'(g);
    assign w_d64        = 64'(r_delay);
    assign w_start      = (w_cnt64 == w_d64 + 64'd1);
    assign w_win_next   = (r_state == S_RUN) && (w_cnt64 >= w_d64 + 64'd1) &&
                          (w_cnt64 < w_d64 + 64'd1 + BURST64);
    assign w_phase_next = (w_start || (r_phase == PH_W'(2 * HALF - 1))) ? '0 : r_phase + PH_W'(1);

    // Per-element delay (loaded at the end of t=0) and square-wave generator.
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        r_delay <= '0;
        r_phase <= '0;
        r_tx    <= 1'b0;
        r_win   <= 1'b0;
      end else begin
        if (w_at_zero) begin
          r_delay <= DELAY_WIDTH'((CYCLE_DELAY * w_k * 64'(r_sin)) >> (SIN_WIDTH - 1));
        end
        r_phase <= w_phase_next;
        r_win   <= w_win_next;
        r_tx    <= w_win_next && (w_phase_next < PH_W'(HALF));
      end
    end

    assign w_tx[g]  = r_tx;
    assign w_win[g] = r_win;
  end

  assign tx_out           = w_tx;
  assign burst_active_out = |w_win;
  assign period_start_out = r_pstart;

endmodule
